// File: rtl/psum_accumulator.sv
// Accumulates NUM_CHUNKS adder-tree results into one wide sum and queues finished sums in a show-ahead FIFO.
// Optional saturation with a per-entry sticky flag is enabled by defining PSUM_SAT_EN.
module psum_accumulator #(
  parameter int PARTIAL_SUM_BW = 20,
  parameter int ACC_BW         = 24,
  parameter int NUM_CHUNKS     = 4,
  parameter int FIFO_DEPTH     = 4,
  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [PARTIAL_SUM_BW-1:0] in_sum,
  output logic        [CW-1:0]             chunk_idx,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [ACC_BW-1:0]         out_data,
  output logic                             out_sat
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

  logic        [CW-1:0]     r_chunk;
  logic signed [ACC_BW-1:0] r_acc;
  logic signed [ACC_BW-1:0] r_mem [FIFO_DEPTH];
  logic        [AW-1:0]     r_wr_ptr;
  logic        [AW-1:0]     r_rd_ptr;
  logic        [CNTW-1:0]   r_count;

  logic signed [ACC_BW-1:0] w_ext;
  logic signed [ACC_BW-1:0] w_step;
  logic                     w_full;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_push;
  logic                     w_pop;

`ifdef PSUM_SAT_EN
  localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

  logic              r_grp_sat;
  logic              r_sat_mem [FIFO_DEPTH];
  logic [ACC_BW:0]   w_wide;
  logic              w_ovf;
  logic              w_grp_sat_nxt;

  // Widened add: overflow shows as disagreement of the two top bits.
  always_comb begin
    w_wide        = {r_acc[ACC_BW-1], r_acc} + {w_ext[ACC_BW-1], w_ext};
    w_ovf         = (r_chunk != {CW{1'b0}}) && (w_wide[ACC_BW] != w_wide[ACC_BW-1]);
    w_grp_sat_nxt = 1'b0;
    w_step        = w_ext;
    if (r_chunk == {CW{1'b0}}) begin
      w_step        = w_ext;
      w_grp_sat_nxt = 1'b0;
    end else begin
      w_grp_sat_nxt = r_grp_sat | w_ovf;
      if (w_ovf) begin
        w_step = w_wide[ACC_BW] ? ACC_MIN : ACC_MAX;
      end else begin
        w_step = w_wide[ACC_BW-1:0];
      end
    end
  end
`else
  // Wrapping accumulate; chunk 0 starts a fresh group.
  always_comb begin
    w_step = w_ext;
    if (r_chunk == {CW{1'b0}}) begin
      w_step = w_ext;
    end else begin
      w_step = r_acc + w_ext;
    end
  end
`endif

  assign w_ext    = ACC_BW'(in_sum);
  assign w_full   = (r_count == CNTW'(FIFO_DEPTH));
  assign in_ready = ~w_full & ~rst;
  assign w_accept = in_valid & in_ready & ~clear;
  assign w_last   = (r_chunk == LAST_CHUNK);
  assign w_push   = w_accept & w_last;
  assign out_valid = (r_count != {CNTW{1'b0}});
  assign w_pop    = out_valid & out_ready;
  assign chunk_idx = r_chunk;
  assign out_data = out_valid ? r_mem[r_rd_ptr] : {ACC_BW{1'b0}};
`ifdef PSUM_SAT_EN
  assign out_sat  = out_valid ? r_sat_mem[r_rd_ptr] : 1'b0;
`else
  assign out_sat  = 1'b0;
`endif

  // Group state: accumulator, chunk counter and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_acc   <= {ACC_BW{1'b0}};
      r_chunk <= {CW{1'b0}};
`ifdef PSUM_SAT_EN
      r_grp_sat <= 1'b0;
`endif
    end else if (w_accept) begin
      if (w_last) begin
        r_acc   <= {ACC_BW{1'b0}};
        r_chunk <= {CW{1'b0}};
`ifdef PSUM_SAT_EN
        r_grp_sat <= 1'b0;
`endif
      end else begin
        r_acc   <= w_step;
        r_chunk <= r_chunk + CW'(1);
`ifdef PSUM_SAT_EN
        r_grp_sat <= w_grp_sat_nxt;
`endif
      end
    end
  end

  // FIFO storage needs no reset; validity comes from the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_step;
`ifdef PSUM_SAT_EN
      r_sat_mem[r_wr_ptr] <= w_grp_sat_nxt;
`endif
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CNTW{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator (default instance plus a 20-bit, 2-chunk instance).
module tb_psum_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] in_sum;
  logic        [1:0]  chunk_idx;
  logic               out_valid;
  logic               out_ready;
  logic signed [23:0] out_data;
  logic               out_sat;

  logic               b_in_valid;
  logic               b_in_ready;
  logic signed [19:0] b_in_sum;
  logic        [0:0]  b_chunk_idx;
  logic               b_out_valid;
  logic signed [19:0] b_out_data;
  logic               b_out_sat;

  integer n_cmp = 0;
  integer n_err = 0;

  always #5 clk = ~clk;

  psum_accumulator u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .chunk_idx(chunk_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  psum_accumulator #(.PARTIAL_SUM_BW(20), .ACC_BW(20), .NUM_CHUNKS(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sum(b_in_sum), .chunk_idx(b_chunk_idx), .out_valid(b_out_valid), .out_ready(1'b1),
    .out_data(b_out_data), .out_sat(b_out_sat)
  );

  task automatic chk(input string tag, input integer got, input integer exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input integer v);
    in_valid = 1'b1;
    in_sum   = v[19:0];
    tick();
    in_valid = 1'b0;
  endtask

  task automatic group4(input integer v);
    for (int k = 0; k < 4; k++) beat(v);
  endtask

  integer sent;
  integer got;
  integer exp_b_data;
  integer exp_b_sat;

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_sum = '0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_chunk", chunk_idx, 0);
    chk("rst_in_ready_after", in_ready, 1);

    // Test 1: basic group with chunk index sequence.
    chk("t1_chunk0", chunk_idx, 0); beat(100);
    chk("t1_chunk1", chunk_idx, 1); beat(200);
    chk("t1_chunk2", chunk_idx, 2); beat(-50);
    chk("t1_chunk3", chunk_idx, 3); beat(7);
    chk("t1_chunk_wrap", chunk_idx, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 257);
    chk("t1_sat", out_sat, 0);
    tick();
    chk("t1_drained", out_valid, 0);

    // Test 2: backpressure, 5 groups into a 4-deep FIFO.
    out_ready = 1'b0;
    in_sum = 20'sd1;
    sent = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid = (sent < 20);
      if (in_valid && in_ready) sent = sent + 1;
      tick();
    end
    chk("t2_accepted_when_full", sent, 16);
    chk("t2_in_ready_full", in_ready, 0);
    chk("t2_chunk_held", chunk_idx, 0);
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 80 && got < 5; i++) begin
      in_valid = (sent < 20);
      if (in_valid && in_ready) sent = sent + 1;
      if (out_valid) begin
        chk("t2_out_data", out_data, 4);
        got = got + 1;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("t2_out_count", got, 5);
    chk("t2_sent", sent, 20);
    tick();
    chk("t2_no_dup", out_valid, 0);

    // Test 3: most negative inputs fit in the wider accumulator.
    group4(-524288);
    chk("t3_valid", out_valid, 1);
    chk("t3_data", out_data, -2097152);
    chk("t3_sat", out_sat, 0);
    tick();

    // Test 4: overflow in the narrow instance.
`ifdef PSUM_SAT_EN
    exp_b_data = 524287; exp_b_sat = 1;
`else
    exp_b_data = -2; exp_b_sat = 0;
`endif
    b_in_valid = 1'b1; b_in_sum = 20'sd524287;
    tick(); tick();
    b_in_valid = 1'b0;
    chk("t4_valid", b_out_valid, 1);
    chk("t4_data", b_out_data, exp_b_data);
    chk("t4_sat", b_out_sat, exp_b_sat);

    // Test 5: clear drops a partial group and a coincident beat, FIFO untouched.
    out_ready = 1'b0;
    group4(5);
    beat(10); beat(10);
    clear = 1'b1; in_valid = 1'b1; in_sum = 20'sd99;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("t5_chunk_cleared", chunk_idx, 0);
    group4(1);
    chk("t5_head", out_data, 20);
    out_ready = 1'b1;
    tick();
    chk("t5_second_valid", out_valid, 1);
    chk("t5_second", out_data, 4);
    tick();
    chk("t5_empty", out_valid, 0);

    // Test 6: reset with FIFO occupied and a group in flight.
    out_ready = 1'b0;
    group4(2);
    group4(1);
    beat(9); beat(9);
    chk("t6_chunk_mid", chunk_idx, 2);
    chk("t6_occupied", out_valid, 1);
    rst = 1'b1; in_valid = 1'b1; in_sum = 20'sd50;
    #1;
    chk("t6_in_ready_rst", in_ready, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_chunk", chunk_idx, 0);
    group4(3);
    chk("t6_valid", out_valid, 1);
    chk("t6_data", out_data, 12);
    out_ready = 1'b1;
    tick();
    chk("t6_single", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
